// File: rtl/sfp_pkg.sv
// Shared definitions for the sfp float format (sign, exponent, mantissa with hidden one)
// and the fixed-point geometry used by both fix-to-sfp and sfp-to-fix conversion.
package sfp_pkg;

    localparam int EXP_WIDTH    = 4;
    localparam int SIG_WIDTH    = 4;
    localparam int FORMAT_WIDTH = 1 + EXP_WIDTH + SIG_WIDTH;
    localparam int FIX_WIDTH    = 21;
    localparam int LSB_OFFSET   = 3;
    localparam int POS_WIDTH    = $clog2(FIX_WIDTH);
    localparam int EXP_MAX      = 2**EXP_WIDTH - 1;

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] expo;
        logic [SIG_WIDTH-1:0] mant;
    } sfp_t;

    // Exponent 0 is reserved for zero, so the all-zero word is the only zero.
    localparam sfp_t SFP_ZERO = '0;
    localparam logic [EXP_WIDTH+SIG_WIDTH-1:0] SFP_SAT_MAG = '1;

    function automatic sfp_t sfp_saturate(input logic sign);
        return {sign, SFP_SAT_MAG};
    endfunction

endpackage

// File: rtl/lead_one_det.sv
// Combinational leading-one detector: index of the highest set bit of vec,
// plus a zero flag (pos reads 0 when vec is all zeros).
module lead_one_det #(
    parameter int WIDTH = 21,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) pos = POS_W'(i);
        end
    end

    assign zero = ~|vec;

endmodule

// File: rtl/fix2sfp_pipe.sv
// Three-stage valid/ready converter from 21-bit two's-complement fixed point to sfp.
// Optional sticky overflow/underflow status: define FIX2SFP_STATUS_EN.
module fix2sfp_pipe
    import sfp_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FIX_WIDTH-1:0]    fix_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FORMAT_WIDTH-1:0] sfp_out
`ifdef FIX2SFP_STATUS_EN
    ,
    input  logic                    clr_flags,
    output logic                    ovf_flag,
    output logic                    unf_flag
`endif
);

    localparam int EXPC_W = EXP_WIDTH + 2;

    logic v1, v2;
    logic load1, load2, load3;

    // S1 state
    logic                 sign1;
    logic [FIX_WIDTH-1:0] mag1;

    // S2 state
    logic                 sign2, zero2, guard2, sticky2;
    logic [POS_WIDTH-1:0] p2;
    logic [SIG_WIDTH-1:0] mant2;

    // S2 combinational
    logic [POS_WIDTH-1:0] lod_pos;
    logic                 lod_zero;
    logic [POS_WIDTH-1:0] shamt;
    logic [FIX_WIDTH-2:0] norm_frac;

    // S3 combinational
    logic [EXPC_W-1:0]    exp_raw, exp_rnd;
    logic [SIG_WIDTH:0]   mant_r;
    logic                 flush, round_up, sat;
    sfp_t                 result;

    // A stage may load when it is empty or its successor is loading this cycle.
    assign load3    = ~out_valid | out_ready;
    assign load2    = ~v2 | load3;
    assign load1    = ~v1 | load2;
    assign in_ready = load1 & ~rst;

    lead_one_det #(.WIDTH(FIX_WIDTH), .POS_W(POS_WIDTH)) u_lod (
        .vec  (mag1),
        .pos  (lod_pos),
        .zero (lod_zero)
    );

    // Shift the leading one into the bit just above norm_frac, dropping it (it is hidden).
    assign shamt     = POS_WIDTH'(FIX_WIDTH - 1) - lod_pos;
    assign norm_frac = (FIX_WIDTH-1)'(mag1 << shamt);

    always_comb begin
        exp_raw  = EXPC_W'(p2) - EXPC_W'(LSB_OFFSET);
        flush    = zero2 | (p2 < POS_WIDTH'(LSB_OFFSET + 1));
        round_up = guard2 & (sticky2 | mant2[0]);
        mant_r   = {1'b0, mant2} + {{SIG_WIDTH{1'b0}}, round_up};
        exp_rnd  = exp_raw + {{(EXPC_W-1){1'b0}}, mant_r[SIG_WIDTH]};
        sat      = ~flush & (exp_rnd > EXPC_W'(EXP_MAX));
        result   = SFP_ZERO;
        if (sat)
            result = sfp_saturate(sign2);
        else if (!flush)
            result = '{sign: sign2, expo: exp_rnd[EXP_WIDTH-1:0], mant: mant_r[SIG_WIDTH-1:0]};
    end

    // Control and output register; a mantissa carry leaves mant_r low bits at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            sfp_out   <= '0;
        end else begin
            if (load1) v1        <= in_valid;
            if (load2) v2        <= v1;
            if (load3) out_valid <= v2;
            if (load3 && v2) sfp_out <= result;
        end
    end

    // NOTE: payload registers are not reset; the valid bits alone decide whether their contents matter.
    always_ff @(posedge clk) begin
        if (load1 && in_valid) begin
            sign1 <= fix_in[FIX_WIDTH-1];
            mag1  <= fix_in[FIX_WIDTH-1] ? -fix_in : fix_in;
        end
        if (load2 && v1) begin
            sign2   <= sign1;
            zero2   <= lod_zero;
            p2      <= lod_pos;
            mant2   <= norm_frac[FIX_WIDTH-2 -: SIG_WIDTH];
            guard2  <= norm_frac[FIX_WIDTH-2-SIG_WIDTH];
            sticky2 <= |norm_frac[FIX_WIDTH-3-SIG_WIDTH:0];
        end
    end

`ifdef FIX2SFP_STATUS_EN
    logic sat3, unf3;

    always_ff @(posedge clk) begin
        if (load3 && v2) begin
            sat3 <= sat;
            unf3 <= flush & ~zero2;
        end
    end

    // Flags accumulate on the output handshake; a clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst || clr_flags) begin
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else if (out_valid && out_ready) begin
            ovf_flag <= ovf_flag | sat3;
            unf_flag <= unf_flag | unf3;
        end
    end
`endif

endmodule

// File: doc/fix2sfp_pipe.md
Name: fix2sfp_pipe

Overview:
- Pipelined converter from 21-bit two's-complement fixed point to the 9-bit sfp float format (sign, 4-bit exponent, 4-bit mantissa, hidden one).
- It is the inverse of the sfp-to-fixed expansion.
- It sits after the Hadamard/FFT fixed-point accumulators and re-packs each sum to sfp for storage or the next stage.
- Valid/ready streaming with full backpressure; throughput of one sample per cycle.

Parameters:
- EXP_WIDTH, 4, exponent field width
- SIG_WIDTH, 4, stored mantissa width (hidden one excluded)
- FORMAT_WIDTH, 9, sfp word width (1+EXP_WIDTH+SIG_WIDTH)
- FIX_WIDTH, 21, fixed-point input width, two's complement
- LSB_OFFSET, 3, fixed bit index of hidden one = exponent + LSB_OFFSET

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fix_in valid
- in_ready  out  1  block can accept fix_in this cycle
- fix_in  in  FIX_WIDTH  two's-complement fixed value
- out_valid  out  1  sfp_out valid
- out_ready  in  1  downstream accepts sfp_out
- sfp_out  out  FORMAT_WIDTH  {sign, exp, mant}

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: out_valid=0, sfp_out=0, all stage valids=0. In-flight data is discarded on reset, including mid-operation. in_ready=0 while rst is high.
- Transfer occurs on valid&ready at a clk edge.
- Three registered stages, latency 3 cycles from accept to out_valid when there is no stall.
  - S1: capture sign = fix_in[MSB]; magnitude = sign ? -fix_in : fix_in, as a FIX_WIDTH-bit unsigned value (-2^20 gives 2^20).
  - S2: leading-one position p of magnitude (0 if magnitude==0); left-normalise so the hidden one sits in a fixed slot; retain guard bit and sticky OR of all lower bits.
  - S3: round, pack and saturate (rules below) into sfp_out.
- Advance rule: stage k loads when it is empty or stage k+1 loads in the same cycle. Output stage loads when out_valid=0 or out_ready=1.
  - in_ready = ~S1_valid | S1 advancing. This is combinational from out_ready through the chain; no bubbles.
  - Full pipe with out_ready=1 and in_valid=1 accepts and emits in the same cycle.
  - out_valid=1 with out_ready=0: sfp_out and all stages hold stable.
- Arithmetic:
  - exp = p - LSB_OFFSET.
  - mant = the SIG_WIDTH bits below p.
  - Rounding is round-to-nearest-even using guard (bit p-SIG_WIDTH-1) and sticky. Missing low bits are treated as 0.
  - Mantissa carry-out increments exp and sets mant=0.
- Boundaries:
  - magnitude==0, or p < LSB_OFFSET+1 (exp<1): output all-zero 9'h000, sign forced 0 (no negative zero).
  - exp > 2^EXP_WIDTH-1, before or after rounding carry: saturate to {sign, 4'hF, 4'hF}.
  - Exponent 0 is reserved for zero; there are no subnormals.

Optional Feature:
- Macro: FIX2SFP_STATUS_EN.
- When defined, add ports:
  - clr_flags  in  1  clears both sticky flags
  - ovf_flag  out  1  sticky; sets when an emitted sample saturated
  - unf_flag  out  1  sticky; sets when a nonzero input flushed to zero
- Flags set on the output handshake. Both reset to 0. clr_flags has priority over a same-cycle set.
- When not defined, these ports and their logic are absent; datapath behaviour is identical.

Decomposition:
- Shared package sfp_pkg holds:
  - field widths
  - LSB_OFFSET
  - the saturation constant (exp/mant all ones)
  - the zero constant
  - a struct/typedef for {sign, exp, mant}
- sfp2fix uses the same package.
- One natural sub-module: lead_one_det (combinational leading-one position of a FIX_WIDTH vector plus a zero flag), instantiated in S2.

Test Plan:
- fix_in 21'h000100 -> 9'h050. fix_in 21'h1FFF00 -> 9'h150. fix_in 0 -> 9'h000. Each appears 3 cycles after accept.
- Rounding: 21'h000118 (tie, odd mant) -> 9'h052. 21'h000108 (tie, even mant 0000) -> 9'h050. 21'h00010C -> 9'h051.
- Saturation/flush:
  - 21'h080000 -> 9'h0FF.
  - 21'h100000 -> 9'h1FF.
  - 21'h07FFFF -> round carry -> 9'h0FF.
  - 21'h000008 -> 9'h000.
  - 21'h1FFFF8 -> 9'h000.
  - With FIX2SFP_STATUS_EN defined, ovf_flag/unf_flag set as expected.
- Backpressure: stream 8 samples with in_valid held high, out_ready low for cycles 2-7. in_ready drops once 3 samples are held. No loss or duplication; order preserved; sfp_out stable while stalled.
- Throughput: continuous in_valid and out_ready for 100 random samples. One output per cycle after 3-cycle fill; matches the reference model bit-exact.
- Reset mid-stream: assert rst with 3 samples in flight. Next cycle out_valid=0 and sfp_out=0. After release, no stale sample is emitted.
